// File: rtl/wave_gen.sv
// wave_gen: frame-aligned waveform sample source for the PWM DAC stage.
module wave_gen #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned FRAME_W = 8,
  parameter int unsigned DIV_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  output logic [DATA_W-1:0] out,
  output logic              step,
  output logic              wrap,
  output logic              frame_tick
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [DIV_W-1:0]   div_cnt_q,   div_cnt_d;
  logic [DATA_W-1:0]  phase_q,     phase_d;
  logic [DATA_W-1:0]  out_q,       out_d;
  logic               step_q,      step_d;
  logic               wrap_q,      wrap_d;
  logic [1:0]         mode_q,      mode_d;
  dir_e               dir_q,       dir_d;

  logic               adv;
  logic [DATA_W-1:0]  phase_inc;
  logic [DATA_W-1:0]  out_inc;
  logic [DATA_W-1:0]  out_dec;

  assign frame_tick = &frame_cnt_q;
  assign adv        = frame_tick && en && (div_cnt_q >= div);
  assign phase_inc  = phase_q + 1'b1;
  assign out_inc    = out_q + 1'b1;
  assign out_dec    = out_q - 1'b1;

  always_comb begin
    frame_cnt_d = frame_cnt_q + 1'b1;
    div_cnt_d   = div_cnt_q;
    phase_d     = phase_q;
    out_d       = out_q;
    mode_d      = mode_q;
    dir_d       = dir_q;
    step_d      = 1'b0;
    wrap_d      = 1'b0;

    if (frame_tick && en) begin
      div_cnt_d = adv ? '0 : div_cnt_q + 1'b1;
    end

    if (adv) begin
      step_d = 1'b1;
      if (mode != mode_q) begin
        mode_d  = mode;
        phase_d = '0;
        dir_d   = DIR_UP;
        case (mode)
          2'b00:   out_d = '0;
          2'b01:   out_d = '1;
          2'b10:   out_d = '0;
          default: out_d = '1;
        endcase
      end else begin
        phase_d = phase_inc;
        case (mode_q)
          2'b00: begin
            out_d  = phase_inc;
            wrap_d = (phase_inc == '0);
          end
          2'b01: begin
            out_d  = ~phase_inc;
            wrap_d = (phase_inc == '0);
          end
          2'b11: begin
            out_d  = phase_inc[DATA_W-1] ? '0 : '1;
            wrap_d = (phase_inc == '0);
          end
          default: begin
            // Triangle turns on the peak values so neither 0 nor all-ones repeats.
            if (dir_q == DIR_UP) begin
              out_d = out_inc;
              if (out_inc == '1) begin
                dir_d = DIR_DOWN;
              end
            end else begin
              out_d = out_dec;
              if (out_dec == '0) begin
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      div_cnt_q   <= '0;
      phase_q     <= '0;
      out_q       <= '0;
      step_q      <= 1'b0;
      wrap_q      <= 1'b0;
      mode_q      <= 2'b00;
      dir_q       <= DIR_UP;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      step_q      <= step_d;
      wrap_q      <= wrap_d;
      mode_q      <= mode_d;
      dir_q       <= dir_d;
    end
  end

  assign out  = out_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_wave_gen.sv
// Scoreboard bench for wave_gen; short frames keep full waveform periods cheap.
module tb_wave_gen;
  localparam int unsigned DW        = 8;
  localparam int unsigned FW        = 4;
  localparam int unsigned DVW       = 4;
  localparam int unsigned FRAME_LEN = 1 << FW;

  logic           clk;
  logic           rst;
  logic           en;
  logic [1:0]     mode;
  logic [DVW-1:0] div;
  logic [DW-1:0]  out;
  logic           step;
  logic           wrap;
  logic           frame_tick;

  wave_gen #(.DATA_W(DW), .FRAME_W(FW), .DIV_W(DVW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode       (mode),
    .div        (div),
    .out        (out),
    .step       (step),
    .wrap       (wrap),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  val;
    logic        wr;
  } exp_t;

  exp_t sb[$];

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // reference model state: edges since reset release, frames waited, steps since mode change
  int unsigned n      = 0;
  int unsigned waited = 0;
  int unsigned idx    = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [7:0]  m_out  = 8'd0;

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d, t=%0t)", nm, act, exp, n, $time);
    end
  endtask

  function automatic logic [7:0] wave(input logic [1:0] md, input int unsigned k);
    int unsigned t;
    case (md)
      2'b00:   wave = 8'(k % 256);
      2'b01:   wave = 8'(255 - (k % 256));
      2'b11:   wave = ((k % 256) < 128) ? 8'd255 : 8'd0;
      default: begin
        t = k % 510;
        wave = (t <= 255) ? 8'(t) : 8'(510 - t);
      end
    endcase
  endfunction

  function automatic int unsigned period(input logic [1:0] md);
    period = (md == 2'b10) ? 510 : 256;
  endfunction

  always @(posedge clk) begin
    logic w;
    if (!rst) begin
      n = 0; waited = 0; idx = 0; m_mode = 2'b00; m_out = 8'd0;
      sb.delete();
    end else begin
      n++;
      if ((n % FRAME_LEN) == 0 && en) begin
        if (waited >= int'(div)) begin
          waited = 0;
          if (mode != m_mode) begin
            m_mode = mode;
            idx    = 0;
            m_out  = wave(mode, 0);
            w      = 1'b0;
          end else begin
            idx++;
            m_out = wave(m_mode, idx);
            w     = ((idx % period(m_mode)) == 0);
          end
          sb.push_back('{n, m_out, w});
        end else begin
          waited++;
        end
      end
    end
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      chk("frame_tick", frame_tick, ((n % FRAME_LEN) == FRAME_LEN - 1) ? 1 : 0);
      chk("out", out, m_out);
      if (step) begin
        if (sb.size() == 0) begin
          chk("step_spurious", step, 0);
        end else begin
          e = sb.pop_front();
          chk("step_cycle", n, e.cyc);
          chk("step_out", out, e.val);
          chk("step_wrap", wrap, e.wr);
        end
      end else begin
        chk("wrap_idle", wrap, 0);
        if (sb.size() > 0 && sb[0].cyc <= n) begin
          chk("step_missing", step, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic run(input int unsigned cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; mode = 2'b00; div = '0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_step", step, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_frame_tick", frame_tick, 0);
    rst = 1'b1;

    run(300 * FRAME_LEN);              // saw up through a wrap
    mode = 2'b01; run(20 * FRAME_LEN); // saw down start
    mode = 2'b11; run(270 * FRAME_LEN);
    mode = 2'b10; run(530 * FRAME_LEN);

    mode = 2'b00; div = 4'd3; run(10 * 4 * FRAME_LEN);
    en = 1'b0; run(2000);
    en = 1'b1; run(5 * 4 * FRAME_LEN);
    for (int i = 0; i < 200 && waited != 2; i++) @(negedge clk);
    chk("div_cnt_reached_2", waited, 2);
    div = 4'd0; run(3 * FRAME_LEN);

    repeat (40) begin
      mode = 2'($urandom_range(0, 3));
      div  = 4'($urandom_range(0, 15));
      en   = ($urandom_range(0, 3) != 0);
      run($urandom_range(50, 800));
    end

    en = 1'b1; div = '0; mode = 2'b10;
    run(300 * FRAME_LEN);
    for (int i = 0; i < 64 && (n % FRAME_LEN) != 6; i++) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out", out, 0);
    chk("arst_step", step, 0);
    chk("arst_wrap", wrap, 0);
    chk("arst_frame_tick", frame_tick, 0);
    repeat (3) @(negedge clk);
    mode = 2'b00; div = '0; en = 1'b1;
    rst = 1'b1;
    run(40 * FRAME_LEN);

    run(2);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wave_gen.md
Name: wave_gen

Overview:
- Upstream sample source for the 8-bit PWM DAC stage. Produces a digital waveform sample: sawtooth up, sawtooth down, triangle or square.
- Keeps a frame counter that is bit-identical to the DAC's PWM counter. The sample therefore changes only on the DAC's frame boundary and stays stable for the whole PWM period.
- A programmable divider sets the output frequency as a number of DAC frames per waveform step.

Parameters:
- DATA_W, 8, sample width; must equal the DAC input width.
- FRAME_W, 8, frame counter width; one frame is 2^FRAME_W clocks and matches the DAC counter.
- DIV_W, 4, width of the frame divider select.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  step enable; when low the waveform freezes.
- mode  input  2  waveform select: 00 saw up, 01 saw down, 10 triangle, 11 square.
- div  input  DIV_W  number of frames per step minus 1.
- out  output  DATA_W  current sample; feeds the DAC `in`.
- step  output  1  one-cycle pulse in the first cycle a new `out` is visible.
- wrap  output  1  one-cycle pulse, coincident with `step`, when the waveform completes a period.
- frame_tick  output  1  high while frame_cnt equals all-ones; same cycle as the DAC carry-out.

Behaviour:
- Reset (rst=0, asynchronous): all registers clear immediately and stay clear while rst is low.
  - Cleared registers: frame_cnt, div_cnt, phase, out, step, wrap, mode_q=00, dir=up.
  - frame_tick is combinational and follows frame_cnt=0.
- frame_cnt:
  - Free-running FRAME_W-bit up counter; wraps from all-ones to 0.
  - Always counts, regardless of en.
- Advance condition (adv), evaluated on a rising edge: frame_tick=1 AND en=1 AND div_cnt>=div.
  - The >= comparison ensures that lowering div mid-count takes effect at the next frame.
- On a frame_tick edge with en=1:
  - If adv: div_cnt<=0.
  - Otherwise: div_cnt<=div_cnt+1.
  - If en=0, div_cnt holds.
- Step period: with a constant div, steps occur every (div+1)*2^FRAME_W clocks.
- On an adv edge:
  - step<=1 for exactly one cycle.
  - out and the internal state update on that same edge.
  - The DAC loads on that edge and captures the previous sample. This gives a fixed one-frame latency and means no sample is ever torn.
- Mode change:
  - mode is sampled only on adv edges.
  - If mode != mode_q: mode_q<=mode, phase<=0, dir<=up, out<=start value of the new mode, wrap<=0.
  - Start values: saw up 0; saw down 2^DATA_W-1; triangle 0; square all-ones.
  - Mode changes between adv edges have no effect on out.
- Normal step (mode == mode_q):
  - phase<=phase+1, modulo 2^DATA_W.
  - Saw up: out<=phase+1.
  - Saw down: out<=~(phase+1).
  - Square: out<=all-ones when the MSB of (phase+1) is 0, otherwise 0. High for the first half-period.
  - wrap<=1 when phase+1 == 0, for saw up, saw down and square.
- Triangle state machine, states UP and DOWN:
  - UP: out<=out+1. If out+1 is all-ones, go to DOWN.
  - DOWN: out<=out-1. If out-1 is 0, go to UP and wrap<=1.
  - Peaks are not repeated: 0,1,...,255,254,...,1,0,1,...
  - Period is 2*(2^DATA_W-1) steps.
- Outside adv edges: step<=0, wrap<=0, out holds.
- en low: out, phase, dir and div_cnt hold, and no step/wrap pulses occur; frame_cnt keeps counting. When en rises, div_cnt resumes from its held value.
- Reset asserted mid-frame: all registers clear at once. After release, frame_cnt restarts at 0, in lockstep with the DAC, which shares the same rst.
- All arithmetic is modulo 2^DATA_W; no saturation.

Test Plan (defaults unless stated):
1. Reset alignment: rst low 3 cycles then high; mode=00, div=0, en=1 -> out=0; first step pulse in the cycle after the 256th rising edge, with out=1; frame_tick high on cycles 255, 511, ...
2. Saw up wrap: run 256 steps -> out goes 1..255 then 0; wrap=1 only with the step where out=0; step spacing exactly 256 clocks.
3. Divider with en: div=3 -> steps every 1024 clocks. Drop en for 2000 clocks -> out frozen, no step. Change div to 0 while div_cnt=2 -> next step at the very next frame_tick.
4. Triangle: mode=10 at reset state -> first adv loads out=0 (mode change). Then 255 steps reach 255, next step gives 254; after 510 further steps out=0 with wrap=1.
5. Square and saw down: mode=11 -> out=255 for 128 steps, then 0 for 128 steps, wrap at the return to 255. Mode=01 -> first adv out=255, next 254.
6. Async reset mid-operation: assert rst at frame_cnt=100 with out=37 in triangle DOWN -> out, step, wrap and frame_cnt are 0 before the next clock edge; after release the sequence matches scenario 1.
